// File: rtl/vrf_transfer_sequencer.sv
// Streams words between a vector register file and ready/valid ports.
// The write path is pass-through. The read path has a one-word output register.
module vrf_transfer_sequencer #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 1,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              vrf_we,
    output logic [ADDR_W-1:0] vrf_wa,
    output logic [ADDR_W-1:0] vrf_ra,
    output logic [DATA_W-1:0] vrf_wd,
    input  logic [DATA_W-1:0] vrf_rd,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] ra_q;
    logic [CNT_W-1:0]  rem_q;
    logic              arm_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              capture_d;
    logic              out_hs_d;
    logic              rd_last_d;

    always_comb begin
        cmd_ready = (state_q == IDLE);
        in_ready  = (state_q == WRITE);
        vrf_we    = in_valid & in_ready;
        vrf_wa    = addr_q;
        vrf_wd    = in_data;
        vrf_ra    = (state_q == READ) ? addr_q : ra_q;
        out_valid = out_valid_q;
        out_data  = out_data_q;
        done      = (state_q == DONE);
        out_hs_d  = out_valid_q & out_ready;
        // The first READ cycle only presents the address; capture starts on the next one.
        capture_d = (state_q == READ) && !arm_q && (rem_q != '0) &&
                    (!out_valid_q || out_ready);
        rd_last_d = (rem_q == '0) && (!out_valid_q || out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            ra_q        <= '0;
            rem_q       <= '0;
            arm_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            ra_q <= vrf_ra;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q <= cmd_base;
                        rem_q  <= cmd_count;
                        if (cmd_count == '0) begin
                            state_q <= DONE;
                        end else if (cmd_write) begin
                            state_q <= WRITE;
                        end else begin
                            state_q <= READ;
                            arm_q   <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (vrf_we) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        rem_q  <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                READ: begin
                    arm_q <= 1'b0;
                    if (capture_d) begin
                        out_data_q  <= vrf_rd;
                        out_valid_q <= 1'b1;
                        addr_q      <= addr_q + ADDR_W'(1);
                        rem_q       <= rem_q - CNT_W'(1);
                    end else if (out_hs_d) begin
                        out_valid_q <= 1'b0;
                    end
                    if (rd_last_d) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vrf_transfer_sequencer.sv
// Directed bench for vrf_transfer_sequencer with a two-entry register file model.
module tb_vrf_transfer_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [0:0]  cmd_base;
    logic [3:0]  cmd_count;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        vrf_we;
    logic [0:0]  vrf_wa;
    logic [0:0]  vrf_ra;
    logic [63:0] vrf_wd;
    logic [63:0] vrf_rd;
    logic        done;

    logic [63:0] regs [2];
    int          nvec;
    int          nerr;

    vrf_transfer_sequencer #(.DATA_W(64), .ADDR_W(1), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .vrf_we(vrf_we), .vrf_wa(vrf_wa), .vrf_ra(vrf_ra), .vrf_wd(vrf_wd),
        .vrf_rd(vrf_rd), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (vrf_we) regs[vrf_wa] <= vrf_wd;
    assign vrf_rd = regs[vrf_ra];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [0:0] base, input logic [3:0] cnt);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_base  = base;
        cmd_count = cnt;
        step();
        cmd_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_base = 0; cmd_count = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
        #1 rst_n = 1'b0;
        #1;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
        nvec++; if (in_ready !== 1'b0 || vrf_we !== 1'b0) begin nerr++; $display("FAIL rst_in_ready_we got %0b/%0b want 0/0", in_ready, vrf_we); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done got %0b want 0", done); end
        nvec++; if (out_data !== 64'h0 || vrf_ra !== 1'b0) begin nerr++; $display("FAIL rst_data_ra got %0h/%0h want 0/0", out_data, vrf_ra); end
        step();
        rst_n = 1'b1;
        step();
        nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL rst_cmd_ready got %0b want 1", cmd_ready); end
    endtask

    task automatic test_write();
        in_valid = 1'b1; in_data = 64'h1;
        issue(1'b1, 1'b0, 4'd2);
        nvec++; if (vrf_we !== 1'b1 || vrf_wa !== 1'b0 || vrf_wd !== 64'h1) begin nerr++; $display("FAIL wr_w0 got we=%0b wa=%0h wd=%0h want 1/0/1", vrf_we, vrf_wa, vrf_wd); end
        nvec++; if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL wr_cmd_ready got %0b want 0", cmd_ready); end
        step();
        in_data = 64'h2;
        #1;
        nvec++; if (vrf_we !== 1'b1 || vrf_wa !== 1'b1 || vrf_wd !== 64'h2) begin nerr++; $display("FAIL wr_w1 got we=%0b wa=%0h wd=%0h want 1/1/2", vrf_we, vrf_wa, vrf_wd); end
        step();
        nvec++; if (done !== 1'b1 || vrf_we !== 1'b0 || in_ready !== 1'b0) begin nerr++; $display("FAIL wr_done got done=%0b we=%0b ir=%0b want 1/0/0", done, vrf_we, in_ready); end
        nvec++; if (regs[0] !== 64'h1 || regs[1] !== 64'h2) begin nerr++; $display("FAIL wr_regs got %0h/%0h want 1/2", regs[0], regs[1]); end
        in_valid = 1'b0;
        step();
        nvec++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin nerr++; $display("FAIL wr_idle got done=%0b cr=%0b want 0/1", done, cmd_ready); end
    endtask

    task automatic test_read();
        out_ready = 1'b1;
        issue(1'b0, 1'b0, 4'd2);
        nvec++; if (out_valid !== 1'b0 || vrf_ra !== 1'b0) begin nerr++; $display("FAIL rd_e0 got ov=%0b ra=%0h want 0/0", out_valid, vrf_ra); end
        step();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rd_e1 got ov=%0b want 0", out_valid); end
        step();
        nvec++; if (out_valid !== 1'b1 || out_data !== 64'h1) begin nerr++; $display("FAIL rd_word0 got ov=%0b d=%0h want 1/1", out_valid, out_data); end
        step();
        nvec++; if (out_valid !== 1'b1 || out_data !== 64'h2) begin nerr++; $display("FAIL rd_word1 got ov=%0b d=%0h want 1/2", out_valid, out_data); end
        step();
        nvec++; if (out_valid !== 1'b0 || done !== 1'b1 || cmd_ready !== 1'b0) begin nerr++; $display("FAIL rd_done got ov=%0b done=%0b cr=%0b want 0/1/0", out_valid, done, cmd_ready); end
        step();
        nvec++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin nerr++; $display("FAIL rd_idle got done=%0b cr=%0b want 0/1", done, cmd_ready); end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        issue(1'b0, 1'b1, 4'd2);
        nvec++; if (vrf_ra !== 1'b1) begin nerr++; $display("FAIL wrap_ra0 got %0h want 1", vrf_ra); end
        step();
        step();
        nvec++; if (out_data !== 64'h2 || vrf_ra !== 1'b0) begin nerr++; $display("FAIL wrap_word0 got d=%0h ra=%0h want 2/0", out_data, vrf_ra); end
        step();
        nvec++; if (out_data !== 64'h1 || out_valid !== 1'b1) begin nerr++; $display("FAIL wrap_word1 got d=%0h ov=%0b want 1/1", out_data, out_valid); end
        step();
        nvec++; if (done !== 1'b1 || vrf_ra !== 1'b1) begin nerr++; $display("FAIL wrap_hold got done=%0b ra=%0h want 1/1", done, vrf_ra); end
        step();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        issue(1'b0, 1'b0, 4'd2);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            nvec++; if (out_valid !== 1'b1 || out_data !== 64'h1 || vrf_ra !== 1'b1) begin nerr++; $display("FAIL stall_%0d got ov=%0b d=%0h ra=%0h want 1/1/1", i, out_valid, out_data, vrf_ra); end
        end
        out_ready = 1'b1;
        step();
        nvec++; if (out_valid !== 1'b1 || out_data !== 64'h2) begin nerr++; $display("FAIL stall_word1 got ov=%0b d=%0h want 1/2", out_valid, out_data); end
        step();
        nvec++; if (out_valid !== 1'b0 || done !== 1'b1) begin nerr++; $display("FAIL stall_done got ov=%0b done=%0b want 0/1", out_valid, done); end
        step();
    endtask

    task automatic test_zero_count();
        in_valid = 1'b1; out_ready = 1'b1;
        issue(1'b1, 1'b0, 4'd0);
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL zero_done got %0b want 1", done); end
        nvec++; if (vrf_we !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin nerr++; $display("FAIL zero_quiet got we=%0b ir=%0b ov=%0b want 0/0/0", vrf_we, in_ready, out_valid); end
        step();
        nvec++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin nerr++; $display("FAIL zero_idle got done=%0b cr=%0b want 0/1", done, cmd_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_abort();
        in_valid = 1'b1; in_data = 64'hA5;
        issue(1'b1, 1'b0, 4'd2);
        step();
        rst_n = 1'b0;
        #1;
        nvec++; if (vrf_we !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL abort_now got we=%0b ir=%0b done=%0b want 0/0/0", vrf_we, in_ready, done); end
        step();
        rst_n = 1'b1;
        step();
        nvec++; if (cmd_ready !== 1'b1 || done !== 1'b0 || vrf_we !== 1'b0) begin nerr++; $display("FAIL abort_after got cr=%0b done=%0b we=%0b want 1/0/0", cmd_ready, done, vrf_we); end
        step();
        nvec++; if (done !== 1'b0 || out_valid !== 1'b0) begin nerr++; $display("FAIL abort_late got done=%0b ov=%0b want 0/0", done, out_valid); end
        in_valid = 1'b0;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_stall();
        test_zero_count();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
